mem_access_unit: RTL

Memory-stage load/store engine for the RV64 five-stage pipeline. Consumes the M-stage control bundle (`memreadM`, `memwriteM`, `RW_typeM`) plus the ALU address and store data, runs a request/response transaction on a 64-bit data bus, and returns the aligned, sign- or zero-extended load result. It freezes the pipeline via `stallM` while a transaction is outstanding and flags misaligned or illegal accesses without touching the bus.

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: issues request/response bus transactions,
// rejects misaligned or reserved accesses, and returns extended load data.
module mem_access_unit #(
    localparam int unsigned XLEN = 64,
    localparam int unsigned NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memreadM,
    input  logic            memwriteM,
    input  logic [2:0]      RW_typeM,
    input  logic [XLEN-1:0] addrM,
    input  logic [XLEN-1:0] wdataM,
    output logic            stallM,
    output logic [XLEN-1:0] rdataM,
    output logic            misalignM,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [NB-1:0]   bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ready,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      off_q, off_d;
    logic [2:0]      type_q, type_d;

    logic            access;
    logic            misaligned;
    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_ext;

    assign access = memreadM | memwriteM;

    // Size decode and alignment check; the reserved type is always rejected.
    always_comb begin
        size_mask  = NB'(8'h01);
        misaligned = 1'b0;
        case (RW_typeM[1:0])
            2'b00: begin
                size_mask  = NB'(8'h01);
                misaligned = 1'b0;
            end
            2'b01: begin
                size_mask  = NB'(8'h03);
                misaligned = addrM[0];
            end
            2'b10: begin
                size_mask  = NB'(8'h0F);
                misaligned = |addrM[1:0];
            end
            default: begin
                size_mask  = NB'(8'hFF);
                misaligned = |addrM[2:0];
            end
        endcase
        if (RW_typeM == 3'b111) begin
            misaligned = 1'b1;
        end
    end

    // Select the addressed lane of the returned doubleword and extend it.
    always_comb begin
        lane     = bus_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (type_q)
            3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        off_d       = off_q;
        type_d      = type_q;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    state_d     = S_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = memwriteM;
                    bus_addr_d  = {addrM[XLEN-1:3], 3'b000};
                    bus_wstrb_d = NB'(size_mask << addrM[2:0]);
                    bus_wdata_d = wdataM << {addrM[2:0], 3'b000};
                    off_d       = addrM[2:0];
                    type_d      = RW_typeM;
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    bus_req_d = 1'b0;
                    state_d   = bus_we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            off_q       <= '0;
            type_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            off_q       <= off_d;
            type_q      <= type_d;
        end
    end

    // Stall covers the launch cycle; the DONE cycle lets the pipeline advance.
    assign stallM    = ((state_q == S_IDLE) && access && !misaligned) ||
                       (state_q == S_REQ) || (state_q == S_WAIT);
    assign misalignM = (state_q == S_IDLE) && access && misaligned;

    assign rdataM    = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule
